uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx transmitter among N_REQ byte-stream requesters. Round-robin grant per message,
//  one byte handed to the UART per transmission, fixed inter-byte gap, burst cap against starvation.

---
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte-stream requesters.
// State | meaning: IDLE none granted | SEND accept a byte | WAIT_BUSY frame start | WAIT_DONE frame shifting | GAP idle spacing
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic               tx_clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_wr_en,
  input  logic               tx_busy,
  output logic               active
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND      = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    last_owner_q, last_owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_wr_en_q, tx_wr_en_d;
  logic             last_flag_q, last_flag_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;

  logic             pick_found;
  logic [OW-1:0]    pick_idx;
  int               scan_idx;
  logic             rel_check;
  logic             rel_done;

  // Scan starts just after the previous owner so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = (int'(last_owner_q) + k) % N_REQ;
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = OW'(scan_idx);
      end
    end
  end

  assign rel_done = last_flag_q || (byte_cnt_q == 8'(MAX_BURST));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    tx_data_d    = tx_data_q;
    tx_wr_en_d   = 1'b0;
    last_flag_d  = last_flag_q;
    byte_cnt_d   = byte_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    rel_check    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          byte_cnt_d        = '0;
          state_d           = S_SEND;
        end
      end
      S_SEND: begin
        if (req_valid[owner_q]) begin
          tx_data_d   = req_data[8*int'(owner_q) +: 8];
          tx_wr_en_d  = 1'b1;
          last_flag_d = req_last[owner_q];
          byte_cnt_d  = byte_cnt_q + 8'd1;
          state_d     = S_WAIT_BUSY;
        end else begin
          last_owner_d = owner_q;
          grant_d      = '0;
          state_d      = S_IDLE;
        end
      end
      S_WAIT_BUSY: begin
        // tx_busy is stale while the start pulse is still out
        if (!tx_wr_en_q && tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (GAP_CYCLES > 0) begin
            gap_cnt_d = 8'(GAP_CYCLES - 1);
            state_d   = S_GAP;
          end else begin
            rel_check = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 8'd0) rel_check = 1'b1;
        else                   gap_cnt_d = gap_cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (rel_check) begin
      if (rel_done) begin
        last_owner_d = owner_q;
        grant_d      = '0;
        state_d      = S_IDLE;
      end else begin
        state_d = S_SEND;
      end
    end
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(N_REQ - 1);
      grant_q      <= '0;
      tx_data_q    <= 8'h00;
      tx_wr_en_q   <= 1'b0;
      last_flag_q  <= 1'b0;
      byte_cnt_q   <= 8'd0;
      gap_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      tx_data_q    <= tx_data_d;
      tx_wr_en_q   <= tx_wr_en_d;
      last_flag_q  <= last_flag_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign req_ready = (state_q == S_SEND) ? (grant_q & req_valid) : '0;
  assign grant     = grant_q;
  assign tx_data   = tx_data_q;
  assign tx_wr_en  = tx_wr_en_q;
  assign active    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: UART busy model, byte scoreboard fed by a queue-level
// round-robin/burst-cap model, a vector table for arbitration order, and directed corner cases.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int MB    = 16;
  localparam int GAP   = 5;
  localparam int FRAME = 4;

  logic         tx_clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_last = '0;
  logic         tx_busy = 1'b0;
  logic [N-1:0] req_ready, grant;
  logic [7:0]   tx_data;
  logic         tx_wr_en, active;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .GAP_CYCLES(GAP)) dut (
    .tx_clk(tx_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_data(tx_data),
    .tx_wr_en(tx_wr_en), .tx_busy(tx_busy), .active(active));

  always #5 tx_clk = ~tx_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge tx_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] own_of(input logic [N-1:0] g);
    own_of = 2'd0;
    for (int i = 0; i < N; i++) if (g[i]) own_of = 2'(i);
  endfunction

  // UART model plus byte monitor: busy rises the cycle after the start pulse and lasts FRAME cycles.
  logic [9:0] got[$];
  int  fall_cyc = 0;
  int  busy_left = 0;
  bit  start_pend = 0;
  bit  rel_seen = 1;
  always @(negedge tx_clk) begin
    bit busy_prev;
    #2;
    busy_prev = tx_busy;
    if (rst) begin
      tx_busy = 1'b0; busy_left = 0; start_pend = 0; rel_seen = 1;
    end else begin
      if (start_pend) begin
        tx_busy = 1'b1; busy_left = FRAME; start_pend = 0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin tx_busy = 1'b0; fall_cyc = cyc; end
      end
      if (req_ready != '0)
        check("ready_onehot_owner_notbusy",
              {29'd0, $onehot0(req_ready), (req_ready & ~grant) == '0, busy_prev}, 32'd6);
      if (tx_wr_en) begin
        check("wr_en_while_busy", {31'd0, busy_prev}, 32'd0);
        if (!rel_seen) check("gap_spacing", cyc - fall_cyc, GAP + 2);
        rel_seen   = 0;
        start_pend = 1;
        got.push_back({own_of(grant), tx_data});
      end
      if (grant == '0) rel_seen = 1;
    end
  end

  // Requester byte queues: {last, data}
  logic [8:0] q [N][$];
  logic [9:0] exp_q[$];

  task automatic model();
    logic [8:0] mq [N][$];
    int last, own, cnt;
    bit any;
    logic [8:0] e;
    for (int i = 0; i < N; i++) mq[i] = q[i];
    exp_q.delete();
    last = N - 1;
    forever begin
      any = 0; own = 0;
      for (int k = 1; k <= N; k++)
        if (!any && mq[(last + k) % N].size() > 0) begin any = 1; own = (last + k) % N; end
      if (!any) break;
      cnt = 0;
      do begin
        e = mq[own].pop_front();
        exp_q.push_back({2'(own), e[7:0]});
        cnt++;
      end while (!e[8] && cnt < MB && mq[own].size() > 0);
      last = own;
    end
  endtask

  task automatic do_reset();
    @(negedge tx_clk);
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    repeat (2) @(negedge tx_clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
  endtask

  task automatic run_feed(input int budget);
    logic [N-1:0] pend = '0;
    int n = 0;
    bit empty;
    got.delete();
    while (n < budget) begin
      @(negedge tx_clk);
      for (int i = 0; i < N; i++) if (pend[i]) void'(q[i].pop_front());
      empty = 1;
      for (int i = 0; i < N; i++) begin
        if (q[i].size() > 0) begin
          empty = 0;
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = q[i][0][7:0];
          req_last[i] = q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      #1;
      pend = req_valid & req_ready;
      if (empty && !active) break;
      n++;
    end
    check("feed_done", {31'd0, n < budget}, 32'd1);
  endtask

  task automatic compare_run(input string nm);
    check({nm, "_count"}, got.size(), exp_q.size());
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) check({nm, "_byte"}, got[k], exp_q[k]);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (active && n < lim) begin @(negedge tx_clk); n++; end
    check("idle_timeout", {31'd0, active}, 32'd0);
  endtask

  typedef struct packed {
    logic [N-1:0] valid;
    logic [N-1:0] exp_grant;
    logic [7:0]   exp_data;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int n;
    logic [1:0] order [5];
    tbl[0] = '{4'b1111, 4'b0001, 8'hC0};
    tbl[1] = '{4'b1111, 4'b0010, 8'hC1};
    tbl[2] = '{4'b0101, 4'b0100, 8'hC2};
    tbl[3] = '{4'b0101, 4'b0001, 8'hC0};
    tbl[4] = '{4'b1000, 4'b1000, 8'hC3};
    tbl[5] = '{4'b0110, 4'b0010, 8'hC1};
    tbl[6] = '{4'b0011, 4'b0001, 8'hC0};
    tbl[7] = '{4'b1111, 4'b0010, 8'hC1};
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

    do_reset();
    @(negedge tx_clk);
    check("rst_grant", grant, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wr_en", tx_wr_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_active", active, 0);

    // T1: three-byte message from requester 0
    q[0].push_back(9'h0A1); q[0].push_back(9'h0A2); q[0].push_back(9'h1A3);
    model();
    run_feed(500);
    compare_run("t1");
    check("t1_last_byte", got[2], {2'd0, 8'hA3});
    check("t1_idle_grant", grant, 0);

    // T2: one-byte messages from all, requester 0 has two
    do_reset();
    for (int i = 0; i < N; i++) q[i].push_back(9'h120 + 9'(i));
    q[0].push_back(9'h124);
    model();
    run_feed(1000);
    compare_run("t2");
    for (int k = 0; k < 5; k++) check("t2_order", got[k][9:8], order[k]);

    // T3: requester 1 streams 40 bytes without last; requester 2 waits its turn
    do_reset();
    for (int k = 0; k < 40; k++) q[1].push_back(9'(k + 1));
    q[2].push_back(9'h0E0); q[2].push_back(9'h0E1); q[2].push_back(9'h1E2);
    model();
    run_feed(3000);
    compare_run("t3");
    check("t3_burst_end_owner", got[15][9:8], 1);
    check("t3_handover_owner", got[16][9:8], 2);

    // Arbitration vectors: single-byte messages, one-cycle grant latency
    do_reset();
    for (int r = 0; r < 8; r++) begin
      @(negedge tx_clk);
      req_valid = tbl[r].valid;
      req_last  = '1;
      req_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
      @(negedge tx_clk);
      check("vec_grant", grant, tbl[r].exp_grant);
      check("vec_ready", req_ready, tbl[r].exp_grant);
      @(negedge tx_clk);
      check("vec_wr_en", tx_wr_en, 1);
      check("vec_data", tx_data, tbl[r].exp_data);
      req_valid = '0;
      wait_idle(100);
    end

    // T5: owner drops valid while in SEND
    do_reset();
    @(negedge tx_clk);
    req_valid = 4'b0101; req_last = 4'b0000; req_data = {8'h00, 8'h55, 8'h00, 8'h44};
    @(negedge tx_clk);
    check("t5_grant0", grant, 4'b0001);
    req_valid = 4'b0100;
    @(negedge tx_clk);
    check("t5_release_grant", grant, 0);
    check("t5_release_active", active, 0);
    check("t5_no_wr_en", tx_wr_en, 0);
    @(negedge tx_clk);
    check("t5_next_grant", grant, 4'b0100);
    req_last = 4'b1111;
    @(negedge tx_clk);
    check("t5_data", tx_data, 8'h55);
    req_valid = '0;
    wait_idle(100);

    // T6: reset during WAIT_DONE restores requester 0 priority
    do_reset();
    q[0].push_back(9'h15A);
    model();
    run_feed(200);
    compare_run("t6_pre");
    @(negedge tx_clk);
    req_valid = 4'b0010; req_last = 4'b0010; req_data = {8'h00, 8'h00, 8'h77, 8'h66};
    @(negedge tx_clk);
    check("t6_grant1", grant, 4'b0010);
    @(negedge tx_clk);
    check("t6_wr_en", tx_wr_en, 1);
    req_valid = '0;
    n = 0;
    while (!tx_busy && n < 20) begin @(negedge tx_clk); n++; end
    check("t6_busy_seen", {31'd0, tx_busy}, 1);
    rst = 1'b1; req_valid = 4'b0011; req_last = 4'b1111;
    @(negedge tx_clk);
    check("t6_rst_grant", grant, 0);
    check("t6_rst_active", active, 0);
    check("t6_rst_wr_en", tx_wr_en, 0);
    check("t6_rst_data", tx_data, 0);
    check("t6_rst_ready", req_ready, 0);
    rst = 1'b0;
    @(negedge tx_clk);
    check("t6_prio_after_rst", grant, 4'b0001);
    @(negedge tx_clk);
    req_valid = '0;
    wait_idle(100);

    // Randomized multi-message traffic against the queue model
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        int msgs = $urandom_range(0, 3);
        for (int m = 0; m < msgs; m++) begin
          int len = $urandom_range(1, 24);
          for (int b = 0; b < len; b++)
            q[i].push_back({(b == len - 1), 8'($urandom)});
        end
      end
      model();
      run_feed(8000);
      compare_run("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
